// File: rtl/cpu_trace_buffer.sv
// Trace buffer for the pipelined MIPS CPU: records retired WB-stage instructions in a
// circular buffer, stops a programmable number of entries after a PC trigger, then drains oldest-first.
module cpu_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              arm,
    input  logic [PC_W-1:0]   trig_pc,
    input  logic [ADDR_W-1:0] post_count,
    input  logic              wb_valid,
    input  logic [PC_W-1:0]   wb_pc,
    input  logic [31:0]       wb_instr,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_reg_num,
    input  logic [DATA_W-1:0] wb_data,
    output logic [1:0]        state,
    output logic [ADDR_W:0]   fill_count,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [PC_W-1:0]   rd_pc,
    output logic [31:0]       rd_instr,
    output logic              rd_reg_write,
    output logic [4:0]        rd_reg_num,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [31:0]       instr;
        logic              reg_write;
        logic [4:0]        reg_num;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam logic [ADDR_W:0] FILL_MAX = (ADDR_W + 1)'(DEPTH);

    entry_t            mem [DEPTH];
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic [ADDR_W:0]   fill_q, fill_d;
    logic              capture;
    logic              pop;
    entry_t            rd_entry;

    // Read port: an entry is offered (rd_valid) only in DONE while entries remain; it is
    // consumed on a cycle where rd_valid && rd_ready, and held unchanged until then.
    assign rd_valid = (state_q == S_DONE) && (fill_q != '0);
    assign pop      = rd_valid && rd_ready;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        remaining_d = remaining_q;
        fill_d      = fill_q;
        capture     = 1'b0;
        case (state_q)
            S_ARMED: begin
                if (wb_valid) begin
                    capture = 1'b1;
                    if (wb_pc == trig_pc) begin
                        if (post_count == '0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d     = S_POST;
                            remaining_d = post_count;
                        end
                    end
                end
            end
            S_POST: begin
                if (wb_valid) begin
                    capture     = 1'b1;
                    remaining_d = remaining_q - ADDR_W'(1);
                    if (remaining_q == ADDR_W'(1)) state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                    fill_d   = fill_q - (ADDR_W + 1)'(1);
                    if (fill_q == (ADDR_W + 1)'(1)) state_d = S_IDLE;
                end
            end
            default: ;
        endcase
        if (capture) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            fill_d   = (fill_q == FILL_MAX) ? fill_q : fill_q + (ADDR_W + 1)'(1);
        end
        // Oldest retained entry sits fill entries behind the write pointer; when the
        // buffer is full the low bits of fill are zero and this lands on wr_ptr itself.
        if (state_d == S_DONE && state_q != S_DONE) begin
            rd_ptr_d = wr_ptr_d - fill_d[ADDR_W-1:0];
        end
        if (arm) begin
            state_d     = S_ARMED;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            remaining_d = '0;
            fill_d      = '0;
            capture     = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            remaining_q <= '0;
            fill_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            remaining_q <= remaining_d;
            fill_q      <= fill_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && capture) begin
            mem[wr_ptr_q] <= '{pc: wb_pc, instr: wb_instr, reg_write: wb_reg_write,
                               reg_num: wb_reg_num, data: wb_data};
        end
    end

    assign rd_entry     = rd_valid ? mem[rd_ptr_q] : '0;
    assign rd_pc        = rd_entry.pc;
    assign rd_instr     = rd_entry.instr;
    assign rd_reg_write = rd_entry.reg_write;
    assign rd_reg_num   = rd_entry.reg_num;
    assign rd_data      = rd_entry.data;
    assign rd_last      = rd_valid && (fill_q == (ADDR_W + 1)'(1));
    assign state        = state_q;
    assign fill_count   = fill_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer at DEPTH=8: capture, trigger, wrap, gaps,
// backpressure, minimal capture and interruption by arm/reset.
module tb_cpu_trace_buffer;

    localparam int DEPTH  = 8;
    localparam int PC_W   = 32;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic              arm;
    logic [PC_W-1:0]   trig_pc;
    logic [ADDR_W-1:0] post_count;
    logic              wb_valid;
    logic [PC_W-1:0]   wb_pc;
    logic [31:0]       wb_instr;
    logic              wb_reg_write;
    logic [4:0]        wb_reg_num;
    logic [DATA_W-1:0] wb_data;
    logic [1:0]        state;
    logic [ADDR_W:0]   fill_count;
    logic              rd_valid;
    logic              rd_ready;
    logic [PC_W-1:0]   rd_pc;
    logic [31:0]       rd_instr;
    logic              rd_reg_write;
    logic [4:0]        rd_reg_num;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;

    int n_vec = 0;
    int n_err = 0;
    logic [PC_W-1:0] exp_q[$];

    cpu_trace_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset), .arm(arm), .trig_pc(trig_pc), .post_count(post_count),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr), .wb_reg_write(wb_reg_write),
        .wb_reg_num(wb_reg_num), .wb_data(wb_data), .state(state), .fill_count(fill_count),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_instr(rd_instr),
        .rd_reg_write(rd_reg_write), .rd_reg_num(rd_reg_num), .rd_data(rd_data),
        .rd_last(rd_last)
    );

    // clock / reset
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // WB-side fields derived from the PC so the scoreboard only needs to queue PCs
    function automatic logic [31:0] f_instr(input logic [PC_W-1:0] pc);
        return 32'h8c00_0000 ^ pc;
    endfunction
    function automatic logic f_rw(input logic [PC_W-1:0] pc);
        return pc[3];
    endfunction
    function automatic logic [4:0] f_rn(input logic [PC_W-1:0] pc);
        return pc[6:2];
    endfunction
    function automatic logic [DATA_W-1:0] f_data(input logic [PC_W-1:0] pc);
        return ~pc;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic drive_wb(input logic valid, input logic [PC_W-1:0] pc);
        wb_valid     = valid;
        wb_pc        = pc;
        wb_instr     = f_instr(pc);
        wb_reg_write = f_rw(pc);
        wb_reg_num   = f_rn(pc);
        wb_data      = f_data(pc);
    endtask

    task automatic do_arm(input logic [PC_W-1:0] tpc, input logic [ADDR_W-1:0] pcount);
        arm        = 1'b1;
        trig_pc    = tpc;
        post_count = pcount;
        drive_wb(1'b1, 32'hFFFF_FFFC);
        tick();
        arm = 1'b0;
        drive_wb(1'b0, 32'h0);
    endtask

    // scoreboard drain: mode 0 keeps rd_ready high, mode 1 stalls one cycle in three
    task automatic drain(input int mode);
        int k;
        logic rdy;
        k = 0;
        while (exp_q.size() > 0 && k < 64) begin
            rdy = (mode == 0) || (k % 3 != 0);
            rd_ready = rdy;
            chk("rd_valid", rd_valid, 1);
            chk("rd_state", state, 3);
            chk("rd_fill", fill_count, exp_q.size());
            chk("rd_pc", rd_pc, exp_q[0]);
            chk("rd_instr", rd_instr, f_instr(exp_q[0]));
            chk("rd_reg_write", rd_reg_write, f_rw(exp_q[0]));
            chk("rd_reg_num", rd_reg_num, f_rn(exp_q[0]));
            chk("rd_data", rd_data, f_data(exp_q[0]));
            chk("rd_last", rd_last, exp_q.size() == 1);
            tick();
            if (rdy) void'(exp_q.pop_front());
            k++;
        end
        rd_ready = 1'b0;
        chk("drain_left", exp_q.size(), 0);
        chk("drain_state", state, 0);
        chk("drain_rd_valid", rd_valid, 0);
        chk("drain_rd_pc", rd_pc, 0);
    endtask

    initial begin
        reset = 1'b1;
        arm = 1'b0;
        trig_pc = '0;
        post_count = '0;
        rd_ready = 1'b0;
        drive_wb(1'b0, 32'h0);

        // reset
        tick();
        tick();
        reset = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_fill", fill_count, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_rd_pc", rd_pc, 0);
        chk("rst_rd_instr", rd_instr, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_fields", {rd_reg_write, rd_reg_num}, 0);

        // basic: trigger at 0x14, two post entries
        do_arm(32'h14, 3'd2);
        chk("basic_armed", state, 1);
        chk("basic_fill0", fill_count, 0);
        for (int i = 0; i < 8; i++) begin
            drive_wb(1'b1, 32'(i * 4));
            tick();
            if (i == 5) chk("basic_post", state, 2);
            if (i == 6) chk("basic_rd_idle", rd_valid, 0);
        end
        drive_wb(1'b1, 32'h14);
        chk("basic_done", state, 3);
        chk("basic_fill", fill_count, 8);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        drain(0);
        drive_wb(1'b0, 32'h0);

        // wrap: 20 entries, only the last 8 survive
        do_arm(32'h40, 3'd3);
        for (int i = 0; i < 20; i++) begin
            drive_wb(1'b1, 32'(i * 4));
            tick();
            if (i == 9) chk("wrap_sat_fill", fill_count, 8);
            if (i == 9) chk("wrap_armed", state, 1);
        end
        drive_wb(1'b0, 32'h0);
        chk("wrap_done", state, 3);
        chk("wrap_fill", fill_count, 8);
        for (int i = 12; i < 20; i++) exp_q.push_back(32'(i * 4));
        drain(0);

        // gaps and backpressure: idle cycles carry the trigger PC but must not capture
        do_arm(32'h18, 3'd1);
        for (int i = 0; i < 9; i++) begin
            if (i % 2 == 0) drive_wb(1'b1, 32'(i * 4));
            else drive_wb(1'b0, 32'h18);
            tick();
            if (i == 5) chk("gap_armed", state, 1);
            if (i == 6) chk("gap_post", state, 2);
        end
        drive_wb(1'b0, 32'h0);
        chk("gap_done", state, 3);
        chk("gap_fill", fill_count, 5);
        exp_q.push_back(32'h00);
        exp_q.push_back(32'h08);
        exp_q.push_back(32'h10);
        exp_q.push_back(32'h18);
        exp_q.push_back(32'h20);
        drain(1);

        // minimal: trigger on the first retire, no post entries
        do_arm(32'h00, 3'd0);
        drive_wb(1'b1, 32'h00);
        tick();
        drive_wb(1'b0, 32'h0);
        chk("min_done", state, 3);
        chk("min_fill", fill_count, 1);
        chk("min_last", rd_last, 1);
        exp_q.push_back(32'h00);
        drain(0);

        // interruption: re-arm mid-POST, then reset while DONE
        do_arm(32'h08, 3'd5);
        for (int i = 0; i < 4; i++) begin
            drive_wb(1'b1, 32'(i * 4));
            tick();
        end
        chk("int_post", state, 2);
        chk("int_fill4", fill_count, 4);
        do_arm(32'h08, 3'd0);
        chk("int_rearm_state", state, 1);
        chk("int_rearm_fill", fill_count, 0);
        drive_wb(1'b1, 32'h10);
        tick();
        drive_wb(1'b1, 32'h08);
        tick();
        drive_wb(1'b0, 32'h0);
        chk("int_done", state, 3);
        chk("int_fill2", fill_count, 2);
        chk("int_rd_valid", rd_valid, 1);
        chk("int_rd_pc", rd_pc, 32'h10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("int_rst_state", state, 0);
        chk("int_rst_rd_valid", rd_valid, 0);
        chk("int_rst_fill", fill_count, 0);
        chk("int_rst_rd_pc", rd_pc, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
